// File: rtl/sysid_regs_pkg.sv
// Shared definitions for the sysid_regs register bank: word addresses,
// control/status bit positions and the bus data width.
package sysid_regs_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam logic [2:0] ADR_ID        = 3'd0;
    localparam logic [2:0] ADR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADR_CTRL      = 3'd5;
    localparam logic [2:0] ADR_STATUS    = 3'd6;
    localparam logic [2:0] ADR_UNMAPPED  = 3'd7;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bundle for sysid_regs; the processor side uses the master
// modport and the register bank uses the slave modport.
interface sysid_regs_if
    import sysid_regs_pkg::*;
#(
    parameter int ADDR_W = 3
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/sysid_uptime.sv
// Prescaled free-running uptime counter with enable, synchronous clear and a
// combinational pulse flagging the increment that wraps the counter to zero.
module sysid_uptime #(
    parameter int UPTIME_W = 48,
    parameter int PRESCALE = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clr,
    output logic [UPTIME_W-1:0] count,
    output logic                wrap_pulse
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     r_prescale;
    logic [UPTIME_W-1:0] r_count;
    logic                w_tick;

    assign w_tick = en && (r_prescale == PS_LAST);

    // Clear outranks the increment, so a wrap cannot be flagged on a clear cycle.
    assign wrap_pulse = w_tick && !clr && (&r_count);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_count    <= '0;
        end else if (clr) begin
            r_prescale <= '0;
            r_count    <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
            r_count    <= r_count + UPTIME_W'(1);
        end else if (en) begin
            r_prescale <= r_prescale + PS_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sysid_regs.sv
// System-ID / housekeeping register bank on Avalon-MM with fixed read latency 1.
// Define SYSID_REGS_IRQ_EN to add the CTRL.IE bit and the registered irq output.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [DATA_W-1:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [DATA_W-1:0] TIMESTAMP = 32'd0,
    parameter int                UPTIME_W  = 48,
    parameter int                PRESCALE  = 1,
    parameter int                ADDR_W    = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    sysid_regs_if.slave  bus
`ifdef SYSID_REGS_IRQ_EN
    ,
    output logic         irq
`endif
);

    logic [ADDR_W-1:0]   w_addr;
    logic                w_upperZero;
    logic [2:0]          w_word;
    logic                w_rd;
    logic                w_wr;
    logic                w_wrLane0;
    logic                w_clr;
    logic                w_ie;
    logic [UPTIME_W-1:0] w_count;
    logic                w_wrapPulse;
    logic [DATA_W-1:0]   w_rdMux;

    logic [DATA_W-1:0]   r_readdata;
    logic                r_readdatavalid;
    logic [DATA_W-1:0]   r_hiShadow;
    logic [DATA_W-1:0]   r_scratch;
    logic                r_en;
    logic                r_wrap;

    // Any address with bits set above the 3-bit map folds onto the unmapped word.
    assign w_addr      = bus.address;
    assign w_upperZero = ((32'(w_addr) >> 3) == 32'd0);
    assign w_word      = w_upperZero ? w_addr[2:0] : ADR_UNMAPPED;

    assign w_rd      = bus.read;
    assign w_wr      = bus.write && !bus.read;
    assign w_wrLane0 = w_wr && bus.byteenable[0];
    assign w_clr     = w_wrLane0 && (w_word == ADR_CTRL) && bus.writedata[CTRL_CLR_BIT];

    sysid_uptime #(
        .UPTIME_W (UPTIME_W),
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (r_en),
        .clr        (w_clr),
        .count      (w_count),
        .wrap_pulse (w_wrapPulse)
    );

    always_comb begin
        w_rdMux = '0;
        case (w_word)
            ADR_ID:        w_rdMux = ID_VALUE;
            ADR_TIMESTAMP: w_rdMux = TIMESTAMP;
            ADR_UPTIME_LO: w_rdMux = w_count[31:0];
            ADR_UPTIME_HI: w_rdMux = r_hiShadow;
            ADR_SCRATCH:   w_rdMux = r_scratch;
            ADR_CTRL: begin
                w_rdMux[CTRL_EN_BIT] = r_en;
                w_rdMux[CTRL_IE_BIT] = w_ie;
            end
            ADR_STATUS:    w_rdMux[STATUS_WRAP_BIT] = r_wrap;
            default:       w_rdMux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= w_rdMux;
            end
        end
    end

    // Reading the low word freezes the upper bits so a LO/HI pair is coherent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hiShadow <= '0;
        end else if (w_rd && (w_word == ADR_UPTIME_LO)) begin
            r_hiShadow <= 32'(w_count[UPTIME_W-1:32]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
        end else if (w_wr && (w_word == ADR_SCRATCH)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.byteenable[b]) begin
                    r_scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en <= 1'b1;
        end else if (w_wrLane0 && (w_word == ADR_CTRL)) begin
            r_en <= bus.writedata[CTRL_EN_BIT];
        end
    end

    // A wrap landing in the same cycle as the write-1-to-clear keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrap <= 1'b0;
        end else if (w_wrapPulse) begin
            r_wrap <= 1'b1;
        end else if (w_wrLane0 && (w_word == ADR_STATUS) && bus.writedata[STATUS_WRAP_BIT]) begin
            r_wrap <= 1'b0;
        end
    end

`ifdef SYSID_REGS_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wrLane0 && (w_word == ADR_CTRL)) begin
                r_ie <= bus.writedata[CTRL_IE_BIT];
            end
            r_irq <= r_wrap && r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
`endif

    assign bus.readdata      = r_readdata;
    assign bus.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_regs.sv
// Directed bench for sysid_regs: a register-level model checked every cycle plus
// hand-computed literals; define SYSID_REGS_IRQ_EN to also check irq.
module tb_sysid_regs;
    import sysid_regs_pkg::*;

    localparam logic [31:0] ID = 32'h1234_ABCD;
    localparam logic [31:0] TS = 32'd1363292375;
    localparam int          UW = 48;
    localparam int          PS = 4;
    localparam int          AW = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sysid_regs_if #(.ADDR_W(AW)) bus ();

`ifdef SYSID_REGS_IRQ_EN
    logic irq;
    logic expIrq;
`endif

    sysid_regs #(
        .ID_VALUE  (ID),
        .TIMESTAMP (TS),
        .UPTIME_W  (UW),
        .PRESCALE  (PS),
        .ADDR_W    (AW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SYSID_REGS_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: the registers as software sees them.
    int          mPhase;
    logic [UW-1:0] mCount;
    logic        mEn;
    logic        mIe;
    logic        mWrap;
    logic [31:0] mScratch;
    logic [31:0] mHi;
    logic        mWr;
    logic        mClr;
    logic        mWrapNow;
    logic        expValid;
    logic [31:0] expData;
    int          cyc;

    logic [31:0]   d;
    logic [UW-1:0] forceVal;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] regValue(input logic [2:0] a);
        case (a)
            ADR_ID:        return ID;
            ADR_TIMESTAMP: return TS;
            ADR_UPTIME_LO: return mCount[31:0];
            ADR_UPTIME_HI: return mHi;
            ADR_SCRATCH:   return mScratch;
            ADR_CTRL:      return {29'd0, mIe, 1'b0, mEn};
            ADR_STATUS:    return {31'd0, mWrap};
            default:       return 32'd0;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mPhase   = 0;
            mCount   = '0;
            mEn      = 1'b1;
            mIe      = 1'b0;
            mWrap    = 1'b0;
            mScratch = 32'd0;
            mHi      = 32'd0;
            expValid = 1'b0;
            expData  = 32'd0;
            cyc      = 0;
`ifdef SYSID_REGS_IRQ_EN
            expIrq   = 1'b0;
`endif
        end else begin
            cyc++;
`ifdef SYSID_REGS_IRQ_EN
            expIrq = mWrap && mIe;
`endif
            mWr  = bus.write && !bus.read;
            mClr = mWr && (bus.address == ADR_CTRL) && bus.byteenable[0] && bus.writedata[1];
            expValid = bus.read;
            if (bus.read) begin
                expData = regValue(bus.address);
                if (bus.address == ADR_UPTIME_LO) mHi = 32'(mCount >> 32);
            end
            mWrapNow = 1'b0;
            if (mClr) begin
                mCount = '0;
                mPhase = 0;
            end else if (mEn) begin
                mPhase++;
                if (mPhase == PS) begin
                    mPhase   = 0;
                    mWrapNow = (mCount == {UW{1'b1}});
                    mCount   = mCount + 48'd1;
                end
            end
            if (mWr) begin
                case (bus.address)
                    ADR_SCRATCH:
                        for (int b = 0; b < 4; b++)
                            if (bus.byteenable[b]) mScratch[8*b +: 8] = bus.writedata[8*b +: 8];
                    ADR_CTRL:
                        if (bus.byteenable[0]) begin
                            mEn = bus.writedata[0];
`ifdef SYSID_REGS_IRQ_EN
                            mIe = bus.writedata[2];
`endif
                        end
                    ADR_STATUS:
                        if (bus.byteenable[0] && bus.writedata[0]) mWrap = 1'b0;
                    default: ;
                endcase
            end
            if (mWrapNow) mWrap = 1'b1;
        end
    end

    always @(negedge clock) begin
        checkOutput("readdatavalid", {31'd0, bus.readdatavalid}, {31'd0, expValid});
        checkOutput("readdata", bus.readdata, expData);
`ifdef SYSID_REGS_IRQ_EN
        checkOutput("irq", {31'd0, irq}, {31'd0, expIrq});
`endif
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be);
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = addr;
        bus.writedata  = wd;
        bus.byteenable = be;
    endtask

    task automatic readWord(input logic [2:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, 32'd0, 4'd0);
        @(negedge clock);
        data = bus.readdata;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic writeWord(input logic [2:0] addr, input logic [31:0] wd, input logic [3:0] be);
        applyStimulus(1'b0, 1'b1, addr, wd, be);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    // Leaves the caller in the cycle whose closing edge increments the counter.
    task automatic waitTick();
        int n = 0;
        while (mPhase != PS - 1 && n < 2 * PS) begin
            @(negedge clock);
            n++;
        end
        if (mPhase != PS - 1) begin
            checks++;
            failures++;
            $display("[TB] FAIL tickWait: prescaler phase %0d, expected %0d", mPhase, PS - 1);
        end
    endtask

    task forceCount(input logic [UW-1:0] v);
        forceVal = v;
        force dut.u_uptime.r_count = forceVal;
        mCount = v;
        #1;
        release dut.u_uptime.r_count;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetValid", {31'd0, bus.readdatavalid}, 32'd0);
        checkOutput("resetData", bus.readdata, 32'd0);
        reset_n = 1'b1;

        readWord(ADR_ID, d);          checkOutput("idWord", d, 32'h1234ABCD);
        readWord(ADR_TIMESTAMP, d);   checkOutput("timestampWord", d, 32'd1363292375);
        writeWord(ADR_SCRATCH, 32'hDEADBEEF, 4'b0101);
        readWord(ADR_SCRATCH, d);     checkOutput("scratchMasked", d, 32'h00AD00EF);
        writeWord(ADR_ID, 32'hFFFF_FFFF, 4'hF);
        readWord(ADR_ID, d);          checkOutput("idAfterWrite", d, 32'h1234ABCD);

        applyStimulus(1'b1, 1'b1, ADR_SCRATCH, 32'h1111_1111, 4'hF);
        @(negedge clock);
        d = bus.readdata;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        checkOutput("readWinsOverWrite", d, 32'h00AD00EF);
        readWord(ADR_SCRATCH, d);     checkOutput("scratchAfterCollide", d, 32'h00AD00EF);
        readWord(ADR_UNMAPPED, d);    checkOutput("unmappedWord", d, 32'd0);

        while (cyc < 40) @(negedge clock);
        readWord(ADR_UPTIME_LO, d);   checkOutput("uptimeAt40", d, 32'd10);
        repeat (100) @(negedge clock);
        readWord(ADR_UPTIME_HI, d);   checkOutput("uptimeHiSmall", d, 32'd0);
        writeWord(ADR_CTRL, 32'd0, 4'b0001);
        repeat (50) @(negedge clock);
        readWord(ADR_UPTIME_LO, d);   checkOutput("uptimeFrozen", d, 32'd35);
        readWord(ADR_CTRL, d);        checkOutput("ctrlDisabled", d, 32'd0);
        writeWord(ADR_CTRL, 32'd1, 4'b0001);

        forceCount(48'h0000_FFFF_FFFF);
        waitTick();
        readWord(ADR_UPTIME_LO, d);   checkOutput("loBeforeCarry", d, 32'hFFFF_FFFF);
        readWord(ADR_UPTIME_HI, d);   checkOutput("hiBeforeCarry", d, 32'd0);
        readWord(ADR_UPTIME_LO, d);   checkOutput("loAfterCarry", d, 32'd0);
        readWord(ADR_UPTIME_HI, d);   checkOutput("hiAfterCarry", d, 32'd1);

        forceCount({UW{1'b1}});
        waitTick();
        @(negedge clock);
        readWord(ADR_STATUS, d);      checkOutput("wrapSet", d, 32'd1);
        readWord(ADR_UPTIME_LO, d);   checkOutput("countAfterWrap", d, 32'd0);

        forceCount({UW{1'b1}});
        waitTick();
        writeWord(ADR_STATUS, 32'd1, 4'b0001);
        readWord(ADR_STATUS, d);      checkOutput("wrapSetBeatsClear", d, 32'd1);
        writeWord(ADR_STATUS, 32'd1, 4'b0001);
        readWord(ADR_STATUS, d);      checkOutput("wrapCleared", d, 32'd0);

        writeWord(ADR_CTRL, 32'd0, 4'b1110);
        readWord(ADR_CTRL, d);        checkOutput("ctrlNeedsLane0", d, 32'd1);
        waitTick();
        writeWord(ADR_CTRL, 32'd3, 4'b0001);
        readWord(ADR_UPTIME_LO, d);   checkOutput("clrBeatsIncrement", d, 32'd0);
        readWord(ADR_CTRL, d);        checkOutput("clrSelfClears", d, 32'd1);
        writeWord(ADR_SCRATCH, 32'h1234_5678, 4'b1010);
        readWord(ADR_SCRATCH, d);     checkOutput("scratchUpperLanes", d, 32'h12AD56EF);

        @(negedge clock);
        applyStimulus(1'b1, 1'b0, ADR_SCRATCH, 32'd0, 4'd0);
        @(posedge clock);
        #1;
        checkOutput("validBeforeReset", {31'd0, bus.readdatavalid}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("validDropsOnReset", {31'd0, bus.readdatavalid}, 32'd0);
        checkOutput("dataClearedOnReset", bus.readdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        readWord(ADR_CTRL, d);        checkOutput("ctrlAfterReset", d, 32'd1);
        readWord(ADR_SCRATCH, d);     checkOutput("scratchAfterReset", d, 32'd0);
        readWord(ADR_STATUS, d);      checkOutput("statusAfterReset", d, 32'd0);
        readWord(ADR_UPTIME_LO, d);   checkOutput("loAfterReset", d, 32'd0);
        readWord(ADR_UPTIME_HI, d);   checkOutput("hiAfterReset", d, 32'd0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
